fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction-fetch stage directly downstream of prog_cnt; consumes its pcout and drives its wen.
- Issues a word fetch to instruction memory over a req/ack handshake and tolerates variable wait states.
- Loads the IF/ID pipeline register and holds one instruction in a skid buffer while decode stalls.
- Handles flush (taken branch or jump) at any point, including during an outstanding fetch.

Parameters:
- DW, 32, instruction/data width.
- AW, 32, address width.
- NOP, 32'h00000000, value loaded into ifid_inst on reset, flush or fault.
- TIMEOUT, 16, max wait cycles for imem_ack (used only with the optional feature).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- pc  in  AW  current PC from prog_cnt pcout.
- stall  in  1  decode cannot accept; hold IF/ID.
- flush  in  1  invalidate IF/ID and any in-flight fetch.
- imem_req  out  1  fetch request.
- imem_addr  out  AW  word address of fetch.
- imem_rdata  in  DW  fetched instruction, valid with imem_ack.
- imem_ack  in  1  fetch complete; sampled only while imem_req=1.
- pc_wen  out  1  one-cycle pulse to prog_cnt wen; advances PC.
- ifid_valid  out  1  IF/ID holds a live instruction.
- ifid_inst  out  DW  instruction to decode.
- ifid_pc  out  AW  address of ifid_inst.
- ifid_pc4  out  AW  ifid_pc+4, truncated to AW bits.
- fetch_err  out  1  fault flag accompanying ifid_valid.

Behaviour:
- Reset (rst=0, async):
  - State goes to ADDR.
  - imem_req=0, imem_addr=0, pc_wen=0, ifid_valid=0, ifid_inst=NOP, ifid_pc=0, ifid_pc4=0, fetch_err=0, kill=0.
- FSM states: ADDR, FETCH, HOLD.
- ADDR: latch pc into fetch_addr; go to FETCH. The cycle exists so prog_cnt's post-wen update is visible.
- FETCH:
  - imem_req=1, imem_addr=fetch_addr; both held stable until ack.
  - ack may arrive in the first FETCH cycle (zero-wait).
  - ack with kill=1: discard rdata, clear kill, no pc_wen, go to ADDR.
  - ack with kill=0 and (!ifid_valid | !stall): load IF/ID (inst=rdata, pc=fetch_addr, pc4=fetch_addr+4, valid=1), pulse pc_wen, go to ADDR.
  - ack with kill=0 and ifid_valid & stall: capture rdata and fetch_addr into the skid buffer, go to HOLD. No pc_wen yet.
- HOLD:
  - imem_req=0.
  - When stall=0: move skid buffer into IF/ID, pulse pc_wen, go to ADDR.
- pc_wen: at most one pulse per accepted instruction; never asserted for discarded fetches.
- IF/ID retire: while stall=0 and no new load occurs, ifid_valid clears after decode consumes it. inst/pc keep their values; only valid drops.
- flush (priority over stall and ack):
  - Next edge: ifid_valid=0, ifid_inst=NOP, fetch_err=0.
  - In FETCH without same-cycle ack: set kill, stay in FETCH. Memory must still see req until ack; no request abandonment.
  - In FETCH with same-cycle ack: discard, go to ADDR.
  - In HOLD: drop skid buffer, go to ADDR.
  - In ADDR: re-latch on the next ADDR pass. The branch unit has already written pc.
- Misaligned pc (pc[1:0]!=0) in ADDR: no request issued. Load IF/ID with NOP, valid=1, fetch_err=1; no pc_wen; stay in ADDR until flush.
- Peak throughput: one instruction per 2 cycles with zero-wait memory.

Optional Feature:
- FETCH_TIMEOUT_EN defined: a wait counter runs in FETCH.
  - If TIMEOUT cycles pass without ack: drop imem_req, load IF/ID with NOP, valid=1, fetch_err=1, no pc_wen, go to ADDR.
  - A later stray ack is ignored because req=0.
- Undefined: no counter; FETCH waits indefinitely. fetch_err is set only by misalignment.

Test Plan:
- Reset then zero-wait memory, pc=0x0 then 0x4 -> ifid_inst=mem[0] with ifid_pc=0x0, ifid_pc4=0x4; next instruction ifid_pc=0x4; pc_wen pulses every 2nd cycle.
- Memory with 3 wait states, pc=0x100 -> imem_req high for 4 cycles, imem_addr=0x100 stable; single pc_wen pulse after ack.
- stall=1 with ifid_valid=1, ack arrives -> HOLD, IF/ID unchanged, no pc_wen; stall drops -> IF/ID takes buffered word, one pc_wen.
- flush two cycles into a 5-wait fetch -> req stays high until ack, data discarded, ifid_valid=0, no pc_wen; next fetch uses new pc=0x200.
- Async rst=0 mid-FETCH -> imem_req=0 and ifid_valid=0 immediately, without waiting for a clock edge; fetch restarts from pc after release.
- pc=0x102 -> no imem_req; ifid_valid=1, fetch_err=1, ifid_inst=NOP. With FETCH_TIMEOUT_EN and ack never asserted -> fetch_err=1 after 16 cycles.

Source files
------------

// File: rtl/fetch_unit.sv
`timescale 1ns/1ps
// Instruction-fetch stage: req/ack fetch from imem into the IF/ID register, with a one-entry skid buffer.
// Define FETCH_TIMEOUT_EN to abort a fetch that waits TIMEOUT cycles for imem_ack.
module fetch_unit #(
   parameter int DW = 32,
   parameter int AW = 32,
   parameter logic [DW-1:0] NOP = 32'h00000000,
   parameter int TIMEOUT = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [AW-1:0] pc,
   input  logic          stall,
   input  logic          flush,
   output logic          imem_req,
   output logic [AW-1:0] imem_addr,
   input  logic [DW-1:0] imem_rdata,
   input  logic          imem_ack,
   output logic          pc_wen,
   output logic          ifid_valid,
   output logic [DW-1:0] ifid_inst,
   output logic [AW-1:0] ifid_pc,
   output logic [AW-1:0] ifid_pc4,
   output logic          fetch_err
);

   typedef enum logic [1:0] {ADDR, FETCH, HOLD} state_t;

   state_t        state, state_nxt;
   logic [AW-1:0] fetch_addr;
   logic [AW-1:0] fault_pc;
   logic [DW-1:0] skid_inst;
   logic [AW-1:0] skid_pc;
   logic          kill, kill_nxt;
   logic          latch_addr, ld_mem, ld_skid, ld_fault, cap_skid;

`ifdef FETCH_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT + 1);
   logic [CW-1:0] wait_cnt;
   logic          timed_out;

   assign timed_out = (state == FETCH) && !imem_ack && (wait_cnt == CW'(TIMEOUT - 1));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         wait_cnt <= '0;
      else if (state != FETCH)
         wait_cnt <= '0;
      else if (!timed_out)
         wait_cnt <= wait_cnt + 1'b1;
   end
`endif

   assign imem_addr = fetch_addr;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= ADDR;
         kill  <= 1'b0;
      end else begin
         state <= state_nxt;
         kill  <= kill_nxt;
      end
   end

   // A flushed in-flight fetch keeps its request up until ack and is then dropped via kill.
   always_comb begin
      state_nxt  = state;
      kill_nxt   = kill;
      imem_req   = 1'b0;
      pc_wen     = 1'b0;
      latch_addr = 1'b0;
      ld_mem     = 1'b0;
      ld_skid    = 1'b0;
      ld_fault   = 1'b0;
      cap_skid   = 1'b0;
      fault_pc   = fetch_addr;
      case (state)
         ADDR: begin
            if (!flush) begin
               if (pc[1:0] != 2'b00) begin
                  fault_pc = pc;
                  ld_fault = !ifid_valid || !stall;
               end else begin
                  latch_addr = 1'b1;
                  state_nxt  = FETCH;
               end
            end
         end
         FETCH: begin
            imem_req = 1'b1;
            if (imem_ack) begin
               if (kill || flush) begin
                  kill_nxt  = 1'b0;
                  state_nxt = ADDR;
               end else if (!ifid_valid || !stall) begin
                  ld_mem    = 1'b1;
                  pc_wen    = 1'b1;
                  state_nxt = ADDR;
               end else begin
                  cap_skid  = 1'b1;
                  state_nxt = HOLD;
               end
`ifdef FETCH_TIMEOUT_EN
            end else if (timed_out) begin
               kill_nxt  = 1'b0;
               ld_fault  = !kill && !flush;
               state_nxt = ADDR;
`endif
            end else if (flush) begin
               kill_nxt = 1'b1;
            end
         end
         HOLD: begin
            if (flush) begin
               state_nxt = ADDR;
            end else if (!stall) begin
               ld_skid   = 1'b1;
               pc_wen    = 1'b1;
               state_nxt = ADDR;
            end
         end
         default: state_nxt = ADDR;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         fetch_addr <= '0;
         skid_inst  <= NOP;
         skid_pc    <= '0;
      end else begin
         if (latch_addr)
            fetch_addr <= pc;
         if (cap_skid) begin
            skid_inst <= imem_rdata;
            skid_pc   <= fetch_addr;
         end
      end
   end

   // Flush wins over every load; otherwise an unstalled decode retires the current entry.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ifid_valid <= 1'b0;
         ifid_inst  <= NOP;
         ifid_pc    <= '0;
         ifid_pc4   <= '0;
         fetch_err  <= 1'b0;
      end else if (flush) begin
         ifid_valid <= 1'b0;
         ifid_inst  <= NOP;
         fetch_err  <= 1'b0;
      end else if (ld_mem) begin
         ifid_valid <= 1'b1;
         ifid_inst  <= imem_rdata;
         ifid_pc    <= fetch_addr;
         ifid_pc4   <= fetch_addr + AW'(4);
         fetch_err  <= 1'b0;
      end else if (ld_skid) begin
         ifid_valid <= 1'b1;
         ifid_inst  <= skid_inst;
         ifid_pc    <= skid_pc;
         ifid_pc4   <= skid_pc + AW'(4);
         fetch_err  <= 1'b0;
      end else if (ld_fault) begin
         ifid_valid <= 1'b1;
         ifid_inst  <= NOP;
         ifid_pc    <= fault_pc;
         ifid_pc4   <= fault_pc + AW'(4);
         fetch_err  <= 1'b1;
      end else if (!stall) begin
         ifid_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
`timescale 1ns/1ps
// Directed testbench for fetch_unit: a wait-state imem responder and per-scenario checking tasks.
module tb_fetch_unit;

   localparam logic [31:0] NOP = 32'h00000000;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] pc;
   logic        stall;
   logic        flush;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic        imem_ack;
   logic        pc_wen;
   logic        ifid_valid;
   logic [31:0] ifid_inst;
   logic [31:0] ifid_pc;
   logic [31:0] ifid_pc4;
   logic        fetch_err;

   int errors = 0;
   int checks = 0;
   int wait_states = 0;
   int resp_cnt = 0;
   int wen_count = 0;
   int req_count = 0;
   logic last_wen = 1'b0;
   logic pc_auto = 1'b0;

   fetch_unit dut (
      .clk       (clk),
      .rst       (rst),
      .pc        (pc),
      .stall     (stall),
      .flush     (flush),
      .imem_req  (imem_req),
      .imem_addr (imem_addr),
      .imem_rdata(imem_rdata),
      .imem_ack  (imem_ack),
      .pc_wen    (pc_wen),
      .ifid_valid(ifid_valid),
      .ifid_inst (ifid_inst),
      .ifid_pc   (ifid_pc),
      .ifid_pc4  (ifid_pc4),
      .fetch_err (fetch_err)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] memword(input logic [31:0] a);
      return 32'hC0DE_0000 ^ a;
   endfunction

   // Instruction memory: acks after wait_states request cycles, updated on the falling edge.
   always @(negedge clk) begin
      if (imem_req === 1'b1) begin
         if (resp_cnt >= wait_states) begin
            imem_ack   = 1'b1;
            imem_rdata = memword(imem_addr);
         end else begin
            imem_ack = 1'b0;
         end
         resp_cnt++;
      end else begin
         imem_ack = 1'b0;
         resp_cnt = 0;
      end
   end

   // One clock: sample handshake outputs just before the edge, return 1ns after it, emulate prog_cnt.
   task automatic tick();
      logic w, r;
      @(negedge clk);
      #4;
      w = pc_wen;
      r = imem_req;
      @(posedge clk);
      #1;
      last_wen = w;
      if (w === 1'b1) begin
         wen_count++;
         if (pc_auto) pc = pc + 32'd4;
      end
      if (r === 1'b1) req_count++;
   endtask

   task automatic do_reset(input logic [31:0] start_pc, input logic auto, input int waits);
      rst = 1'b0;
      stall = 1'b0;
      flush = 1'b0;
      pc = start_pc;
      pc_auto = auto;
      wait_states = waits;
      tick();
      tick();
      rst = 1'b1;
      wen_count = 0;
      req_count = 0;
   endtask

   task automatic test_reset();
      $display("[TB] test_reset");
      rst = 1'b0; stall = 1'b0; flush = 1'b0; pc = 32'h0; imem_ack = 1'b0; imem_rdata = 32'h0;
      #2;
      checks++; if (imem_req !== 1'b0) begin errors++; $display("[TB] FAIL rst_req: got %0h expected 0", imem_req); end
      checks++; if (imem_addr !== 32'h0) begin errors++; $display("[TB] FAIL rst_addr: got %0h expected 0", imem_addr); end
      checks++; if (pc_wen !== 1'b0) begin errors++; $display("[TB] FAIL rst_wen: got %0h expected 0", pc_wen); end
      checks++; if (ifid_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_valid: got %0h expected 0", ifid_valid); end
      checks++; if (ifid_inst !== NOP) begin errors++; $display("[TB] FAIL rst_inst: got %0h expected %0h", ifid_inst, NOP); end
      checks++; if (ifid_pc !== 32'h0 || ifid_pc4 !== 32'h0) begin errors++; $display("[TB] FAIL rst_pc: got %0h/%0h expected 0/0", ifid_pc, ifid_pc4); end
      checks++; if (fetch_err !== 1'b0) begin errors++; $display("[TB] FAIL rst_err: got %0h expected 0", fetch_err); end
   endtask

   task automatic test_zero_wait();
      $display("[TB] test_zero_wait");
      do_reset(32'h0, 1'b1, 0);
      tick();
      checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("[TB] FAIL zw_req0: got req=%0h addr=%0h expected req=1 addr=0", imem_req, imem_addr); end
      checks++; if (ifid_valid !== 1'b0) begin errors++; $display("[TB] FAIL zw_novalid: got %0h expected 0", ifid_valid); end
      tick();
      checks++; if (last_wen !== 1'b1) begin errors++; $display("[TB] FAIL zw_wen0: got %0h expected 1", last_wen); end
      checks++; if (ifid_valid !== 1'b1 || ifid_inst !== memword(32'h0)) begin errors++; $display("[TB] FAIL zw_inst0: got v=%0h inst=%0h expected v=1 inst=%0h", ifid_valid, ifid_inst, memword(32'h0)); end
      checks++; if (ifid_pc !== 32'h0 || ifid_pc4 !== 32'h4) begin errors++; $display("[TB] FAIL zw_pc0: got %0h/%0h expected 0/4", ifid_pc, ifid_pc4); end
      tick();
      checks++; if (last_wen !== 1'b0) begin errors++; $display("[TB] FAIL zw_nowen: got %0h expected 0", last_wen); end
      checks++; if (ifid_valid !== 1'b0) begin errors++; $display("[TB] FAIL zw_retire: got %0h expected 0", ifid_valid); end
      checks++; if (imem_addr !== 32'h4) begin errors++; $display("[TB] FAIL zw_addr1: got %0h expected 4", imem_addr); end
      tick();
      checks++; if (ifid_inst !== memword(32'h4) || ifid_pc !== 32'h4 || ifid_pc4 !== 32'h8) begin errors++; $display("[TB] FAIL zw_inst1: got inst=%0h pc=%0h pc4=%0h expected %0h/4/8", ifid_inst, ifid_pc, ifid_pc4, memword(32'h4)); end
      checks++; if (wen_count !== 2) begin errors++; $display("[TB] FAIL zw_wencount: got %0d expected 2", wen_count); end
      pc = 32'hFFFF_FFFC;
      tick();
      tick();
      checks++; if (ifid_pc !== 32'hFFFF_FFFC || ifid_pc4 !== 32'h0) begin errors++; $display("[TB] FAIL zw_pc4wrap: got %0h/%0h expected fffffffc/0", ifid_pc, ifid_pc4); end
   endtask

   task automatic test_wait_states();
      $display("[TB] test_wait_states");
      do_reset(32'h100, 1'b1, 3);
      tick();
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin errors++; $display("[TB] FAIL ws_hold%0d: got req=%0h addr=%0h expected 1/100", i, imem_req, imem_addr); end
         checks++; if (wen_count !== 0) begin errors++; $display("[TB] FAIL ws_earlywen%0d: got %0d expected 0", i, wen_count); end
      end
      tick();
      checks++; if (ifid_valid !== 1'b1 || ifid_inst !== memword(32'h100)) begin errors++; $display("[TB] FAIL ws_inst: got v=%0h inst=%0h expected 1/%0h", ifid_valid, ifid_inst, memword(32'h100)); end
      checks++; if (req_count !== 4) begin errors++; $display("[TB] FAIL ws_reqcycles: got %0d expected 4", req_count); end
      checks++; if (wen_count !== 1) begin errors++; $display("[TB] FAIL ws_wen: got %0d expected 1", wen_count); end
   endtask

   task automatic test_stall();
      $display("[TB] test_stall");
      do_reset(32'h40, 1'b1, 0);
      tick();
      tick();
      stall = 1'b1;
      tick();
      tick();
      checks++; if (imem_req !== 1'b0) begin errors++; $display("[TB] FAIL st_holdreq: got %0h expected 0", imem_req); end
      checks++; if (ifid_valid !== 1'b1 || ifid_inst !== memword(32'h40) || ifid_pc !== 32'h40) begin errors++; $display("[TB] FAIL st_ifidheld: got v=%0h inst=%0h pc=%0h expected 1/%0h/40", ifid_valid, ifid_inst, ifid_pc, memword(32'h40)); end
      checks++; if (wen_count !== 1) begin errors++; $display("[TB] FAIL st_nowen: got %0d expected 1", wen_count); end
      tick();
      checks++; if (imem_req !== 1'b0 || wen_count !== 1) begin errors++; $display("[TB] FAIL st_hold2: got req=%0h wen=%0d expected 0/1", imem_req, wen_count); end
      stall = 1'b0;
      tick();
      checks++; if (ifid_inst !== memword(32'h44) || ifid_pc !== 32'h44 || ifid_pc4 !== 32'h48) begin errors++; $display("[TB] FAIL st_skid: got inst=%0h pc=%0h pc4=%0h expected %0h/44/48", ifid_inst, ifid_pc, ifid_pc4, memword(32'h44)); end
      checks++; if (wen_count !== 2) begin errors++; $display("[TB] FAIL st_wen: got %0d expected 2", wen_count); end
      tick();
      checks++; if (ifid_valid !== 1'b0 || ifid_inst !== memword(32'h44)) begin errors++; $display("[TB] FAIL st_retire: got v=%0h inst=%0h expected 0/%0h", ifid_valid, ifid_inst, memword(32'h44)); end
   endtask

   task automatic test_flush();
      $display("[TB] test_flush");
      do_reset(32'h80, 1'b1, 0);
      tick();
      tick();
      stall = 1'b1;
      wait_states = 5;
      tick();
      tick();
      tick();
      flush = 1'b1;
      pc = 32'h200;
      pc_auto = 1'b0;
      tick();
      flush = 1'b0;
      stall = 1'b0;
      checks++; if (ifid_valid !== 1'b0 || ifid_inst !== NOP || fetch_err !== 1'b0) begin errors++; $display("[TB] FAIL fl_clear: got v=%0h inst=%0h err=%0h expected 0/%0h/0", ifid_valid, ifid_inst, fetch_err, NOP); end
      checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h84) begin errors++; $display("[TB] FAIL fl_reqkept: got req=%0h addr=%0h expected 1/84", imem_req, imem_addr); end
      tick();
      tick();
      checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h84) begin errors++; $display("[TB] FAIL fl_reqlate: got req=%0h addr=%0h expected 1/84", imem_req, imem_addr); end
      tick();
      checks++; if (imem_req !== 1'b0 || req_count !== 7) begin errors++; $display("[TB] FAIL fl_ackdone: got req=%0h reqcycles=%0d expected 0/7", imem_req, req_count); end
      checks++; if (wen_count !== 1 || ifid_valid !== 1'b0 || ifid_inst !== NOP) begin errors++; $display("[TB] FAIL fl_discard: got wen=%0d v=%0h inst=%0h expected 1/0/%0h", wen_count, ifid_valid, ifid_inst, NOP); end
      wait_states = 0;
      tick();
      checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h200) begin errors++; $display("[TB] FAIL fl_newpc: got req=%0h addr=%0h expected 1/200", imem_req, imem_addr); end
      tick();
      checks++; if (ifid_valid !== 1'b1 || ifid_pc !== 32'h200 || ifid_inst !== memword(32'h200) || wen_count !== 2) begin errors++; $display("[TB] FAIL fl_refetch: got v=%0h pc=%0h inst=%0h wen=%0d expected 1/200/%0h/2", ifid_valid, ifid_pc, ifid_inst, wen_count, memword(32'h200)); end
   endtask

   task automatic test_async_reset();
      $display("[TB] test_async_reset");
      do_reset(32'h300, 1'b1, 0);
      tick();
      tick();
      stall = 1'b1;
      wait_states = 5;
      tick();
      tick();
      #1 rst = 1'b0;
      #1;
      checks++; if (imem_req !== 1'b0 || imem_addr !== 32'h0) begin errors++; $display("[TB] FAIL ar_req: got req=%0h addr=%0h expected 0/0", imem_req, imem_addr); end
      checks++; if (ifid_valid !== 1'b0 || ifid_inst !== NOP || pc_wen !== 1'b0) begin errors++; $display("[TB] FAIL ar_ifid: got v=%0h inst=%0h wen=%0h expected 0/%0h/0", ifid_valid, ifid_inst, pc_wen, NOP); end
      #1 rst = 1'b1;
      stall = 1'b0;
      wait_states = 0;
      tick();
      checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h304) begin errors++; $display("[TB] FAIL ar_restart: got req=%0h addr=%0h expected 1/304", imem_req, imem_addr); end
      tick();
      checks++; if (ifid_valid !== 1'b1 || ifid_pc !== 32'h304 || ifid_inst !== memword(32'h304)) begin errors++; $display("[TB] FAIL ar_load: got v=%0h pc=%0h inst=%0h expected 1/304/%0h", ifid_valid, ifid_pc, ifid_inst, memword(32'h304)); end
   endtask

   task automatic test_misaligned();
      $display("[TB] test_misaligned");
      do_reset(32'h102, 1'b0, 0);
      tick();
      checks++; if (imem_req !== 1'b0) begin errors++; $display("[TB] FAIL ma_noreq: got %0h expected 0", imem_req); end
      checks++; if (ifid_valid !== 1'b1 || fetch_err !== 1'b1 || ifid_inst !== NOP) begin errors++; $display("[TB] FAIL ma_fault: got v=%0h err=%0h inst=%0h expected 1/1/%0h", ifid_valid, fetch_err, ifid_inst, NOP); end
      tick();
      checks++; if (imem_req !== 1'b0 || fetch_err !== 1'b1 || wen_count !== 0 || req_count !== 0) begin errors++; $display("[TB] FAIL ma_stuck: got req=%0h err=%0h wen=%0d reqs=%0d expected 0/1/0/0", imem_req, fetch_err, wen_count, req_count); end
      flush = 1'b1;
      tick();
      flush = 1'b0;
      pc = 32'h104;
      checks++; if (ifid_valid !== 1'b0 || fetch_err !== 1'b0) begin errors++; $display("[TB] FAIL ma_flush: got v=%0h err=%0h expected 0/0", ifid_valid, fetch_err); end
      tick();
      checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h104) begin errors++; $display("[TB] FAIL ma_recover: got req=%0h addr=%0h expected 1/104", imem_req, imem_addr); end
      tick();
      checks++; if (ifid_valid !== 1'b1 || fetch_err !== 1'b0 || ifid_inst !== memword(32'h104)) begin errors++; $display("[TB] FAIL ma_load: got v=%0h err=%0h inst=%0h expected 1/0/%0h", ifid_valid, fetch_err, ifid_inst, memword(32'h104)); end
   endtask

   task automatic test_no_ack();
      $display("[TB] test_no_ack");
      do_reset(32'h500, 1'b0, 100000);
      tick();
      repeat (15) tick();
      checks++; if (imem_req !== 1'b1 || fetch_err !== 1'b0 || ifid_valid !== 1'b0) begin errors++; $display("[TB] FAIL na_wait: got req=%0h err=%0h v=%0h expected 1/0/0", imem_req, fetch_err, ifid_valid); end
      tick();
`ifdef FETCH_TIMEOUT_EN
      checks++; if (imem_req !== 1'b0 || fetch_err !== 1'b1 || ifid_valid !== 1'b1 || ifid_inst !== NOP) begin errors++; $display("[TB] FAIL na_timeout: got req=%0h err=%0h v=%0h inst=%0h expected 0/1/1/%0h", imem_req, fetch_err, ifid_valid, ifid_inst, NOP); end
      checks++; if (req_count !== 16 || wen_count !== 0) begin errors++; $display("[TB] FAIL na_tocount: got reqs=%0d wen=%0d expected 16/0", req_count, wen_count); end
`else
      repeat (8) tick();
      checks++; if (imem_req !== 1'b1 || fetch_err !== 1'b0 || ifid_valid !== 1'b0) begin errors++; $display("[TB] FAIL na_forever: got req=%0h err=%0h v=%0h expected 1/0/0", imem_req, fetch_err, ifid_valid); end
      checks++; if (req_count !== 24 || wen_count !== 0) begin errors++; $display("[TB] FAIL na_count: got reqs=%0d wen=%0d expected 24/0", req_count, wen_count); end
`endif
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      test_reset();
      test_zero_wait();
      test_wait_states();
      test_stall();
      test_flush();
      test_async_reset();
      test_misaligned();
      test_no_ack();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
